// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the shift-register serial path
// (universal_shift_register and shift_register_deserializer).
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_e;

endpackage : shift_reg_pkg

// File: rtl/shift_register_deserializer_if.sv
// Serial-side inputs and parallel valid/ready side of the deserializer.
// The master drives the serial stream and consumes words; the slave is the deserializer.
interface shift_register_deserializer_if
  import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    localparam int CNT_W = $clog2(WIDTH);

    logic             serial_in;
    logic             serial_valid;
    logic             msb_first;
    logic             flush;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_count;
    logic             busy;
    logic             overrun;

    modport master (
        output serial_in, serial_valid, msb_first, flush, out_ready,
        input  parallel_out, out_valid, bit_count, busy, overrun
    );

    modport slave (
        input  serial_in, serial_valid, msb_first, flush, out_ready,
        output parallel_out, out_valid, bit_count, busy, overrun
    );

endinterface : shift_register_deserializer_if

// File: rtl/deser_hold_reg.sv
// One-word valid/ready holding register. A word that completes while the
// previous one is still unconsumed is dropped and flagged with a one-cycle overrun.
module deser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overrun
);

    logic blocked;

    // A consume on the same edge as a load frees the slot, so only a
    // stalled consumer blocks the incoming word.
    assign blocked = out_valid && !out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load_valid) begin
                if (blocked) begin
                    overrun <= 1'b1;
                end else begin
                    parallel_out <= load_data;
                    out_valid    <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : deser_hold_reg

// File: rtl/shift_register_deserializer.sv
// Serial-in, parallel-out receiver: collects WIDTH qualified bits MSB- or
// LSB-first and hands each word to a one-word valid/ready holding register.
module shift_register_deserializer
  import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic                          clk,
    input logic                          reset_n,
    shift_register_deserializer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    deser_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             dir_q, dir_d;
    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_overrun;

    // Direction is taken live on the first bit of a word, then frozen.
    assign eff_dir = (state_q == IDLE) ? bus.msb_first : dir_q;
    assign shifted = (eff_dir == DIR_MSB_FIRST) ? {sr_q[WIDTH-2:0], bus.serial_in}
                                                : {bus.serial_in, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            sr_q    <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sr_q    <= sr_d;
            dir_q   <= dir_d;
        end
    end

    // NOTE: every signal gets its hold value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sr_d     = sr_q;
        dir_d    = dir_q;
        complete = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            count_d = '0;
            sr_d    = '0;
        end else if (bus.serial_valid) begin
            dir_d = eff_dir;
            if (count_q == LAST_IDX) begin
                complete = 1'b1;
                state_d  = IDLE;
                count_d  = '0;
                sr_d     = '0;
            end else begin
                state_d = COLLECT;
                count_d = count_q + CNT_W'(1);
                sr_d    = shifted;
            end
        end
    end

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (complete),
        .load_data   (shifted),
        .out_ready   (bus.out_ready),
        .parallel_out(hold_data),
        .out_valid   (hold_valid),
        .overrun     (hold_overrun)
    );

    assign bus.parallel_out = hold_data;
    assign bus.out_valid    = hold_valid;
    assign bus.overrun      = hold_overrun;
    assign bus.bit_count    = count_q;
    assign bus.busy         = (count_q != '0);

endmodule : shift_register_deserializer

// File: doc/shift_register_deserializer.md
Name: shift_register_deserializer

Overview:
Serial-in, parallel-out receiver: the far end of the universal shift register's serial path. It collects WIDTH qualified serial bits, MSB-first or LSB-first, into a parallel word. It presents the word on a valid/ready output with a one-word holding register, so the downstream consumer can stall without blocking the next word's collection.

Parameters:
- WIDTH, 8, bits per parallel word (≥2)
- CNT_W, $clog2(WIDTH), bit_count width

Ports:
- clk, input, 1, rising-edge clock
- reset_n, input, 1, asynchronous active-low reset
- serial_in, input, 1, serial data bit
- serial_valid, input, 1, serial_in qualified this cycle
- msb_first, input, 1, 1 = first received bit lands in MSB; 0 = first bit lands in LSB
- flush, input, 1, synchronous discard of the partial word
- parallel_out, output, WIDTH, held received word
- out_valid, output, 1, parallel_out holds an unconsumed word
- out_ready, input, 1, consumer accepts the word when out_valid && out_ready
- bit_count, output, CNT_W, bits collected into the current partial word
- busy, output, 1, partial word in progress (bit_count != 0)
- overrun, output, 1, one-cycle pulse: completed word dropped

Behaviour:
- Reset (async assert, sync deassert handled upstream): shift register 0, bit_count 0, parallel_out 0, out_valid 0, overrun 0, FSM IDLE, latched direction 0.
- FSM IDLE (bit_count == 0) / COLLECT (0 < bit_count < WIDTH).
  - IDLE→COLLECT on serial_valid; latch msb_first.
  - COLLECT→IDLE on the WIDTH-th bit or on flush.
- Shift per serial_valid:
  - direction 1: sr <= {sr[WIDTH-2:0], serial_in}
  - direction 0: sr <= {serial_in, sr[WIDTH-1:1]}
  - bit_count increments.
- msb_first is sampled only on the first bit of a word. Changes mid-word are ignored until the next word.
- Completion:
  - On the edge that samples the WIDTH-th bit, the assembled word, including that bit, loads into parallel_out.
  - out_valid = 1 after that edge, so latency is 0 cycles after the last bit edge.
  - bit_count returns to 0 on the same edge.
- Handshake:
  - out_valid && out_ready on an edge clears out_valid.
  - parallel_out holds its value after consumption; there is no clear.
- Simultaneous consume + complete on the same edge: new word loads, out_valid stays 1, no overrun.
- Complete while out_valid && !out_ready:
  - new word is dropped; parallel_out keeps the old word.
  - overrun = 1 for exactly one cycle.
  - collection of the next word proceeds normally.
- flush:
  - bit_count 0, sr 0, FSM IDLE.
  - The holding register and out_valid are untouched.
  - flush wins over serial_valid on the same edge; that bit is discarded.
- serial_valid gaps of any length are legal. The partial word is retained with no timeout.
- reset_n low mid-word or mid-handshake: all state clears immediately; no word is emitted.

Decomposition:
- Shared package (shift_reg_pkg):
  - direction constants DIR_LSB_FIRST = 1'b0 and DIR_MSB_FIRST = 1'b1
  - FSM state typedef {IDLE, COLLECT}
  - default WIDTH constant, shared with universal_shift_register
- Sub-module: deser_hold_reg, the one-word valid/ready holding register with overrun detect. Keeps the shift/count datapath separate from the output handshake.

Test Plan:
- MSB-first: WIDTH=8, msb_first=1, out_ready=1; bits 1,1,1,0,0,1,0,1 on consecutive cycles → after the 8th bit edge parallel_out=8'hE5, out_valid=1 for 1 cycle, bit_count=0.
- LSB-first: same bit sequence with msb_first=0 → parallel_out=8'hA7. Toggling msb_first after bit 3 leaves the result at 8'hA7.
- Backpressure: out_ready=0, send 8'hE5 then 8'h3C → after the 2nd word overrun pulses once, parallel_out stays 8'hE5, out_valid=1. Then out_ready=1 for one cycle → out_valid=0.
- Simultaneous: out_valid=1 (8'hE5) with out_ready=1 on the same edge as the 8th bit of 8'h3C → parallel_out=8'h3C, out_valid=1, overrun=0.
- Gaps and flush: send 4 bits with serial_valid idle 3 cycles between each → bit_count=4, busy=1. Assert flush → bit_count=0. Then send 8'h81 → parallel_out=8'h81.
- Reset mid-word: after 5 bits drop reset_n asynchronously between edges → bit_count, out_valid and parallel_out read 0 immediately. The next full word is received correctly.
